// File: rtl/bus_arbiter.sv
// Two-requester arbiter sharing one downstream memory bus, with round-robin or fixed
// priority and a forced release of transactions that stall past a cycle limit.
module bus_arbiter #(
    parameter int unsigned AddrBusWidth  = 32,
    parameter int unsigned BusWidth      = 32,
    parameter bit          RoundRobin    = 1'b1,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddrBusWidth-1:0] m0_addr,
    input  logic [BusWidth-1:0]     m0_w_data,
    input  logic [BusWidth/8-1:0]   m0_w_sel,
    input  logic                    m0_re,
    input  logic                    m0_we,
    output logic [BusWidth-1:0]     m0_r_data,
    output logic                    m0_ready,
    output logic                    m0_r_data_valid,
    input  logic [AddrBusWidth-1:0] m1_addr,
    input  logic [BusWidth-1:0]     m1_w_data,
    input  logic [BusWidth/8-1:0]   m1_w_sel,
    input  logic                    m1_re,
    input  logic                    m1_we,
    output logic [BusWidth-1:0]     m1_r_data,
    output logic                    m1_ready,
    output logic                    m1_r_data_valid,
    output logic [AddrBusWidth-1:0] s_addr,
    output logic [BusWidth-1:0]     s_w_data,
    output logic [BusWidth/8-1:0]   s_w_sel,
    output logic                    s_re,
    output logic                    s_we,
    input  logic [BusWidth-1:0]     s_r_data,
    input  logic                    s_ready,
    input  logic                    s_r_data_valid,
    output logic [1:0]              grant,
    output logic                    timeout_err
);

    localparam bit          TimeoutEn = (TimeoutCycles > 0);
    localparam int unsigned CntWidth  = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
    // Last count value before the limit; the cycle holding it is the final OWN cycle.
    localparam logic [CntWidth-1:0] LimitM1 =
        TimeoutEn ? CntWidth'(TimeoutCycles - 1) : '0;

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e              state;
    logic                last;
    logic [CntWidth-1:0] cnt;

    logic req0, req1;
    logic complete, abort;

    assign req0 = m0_re | m0_we;
    assign req1 = m1_re | m1_we;

    assign m0_r_data = s_r_data;
    assign m1_r_data = s_r_data;

    assign grant = {state == StOwn1, state == StOwn0};

    always_comb begin
        s_addr          = '0;
        s_w_data        = '0;
        s_w_sel         = '0;
        s_re            = 1'b0;
        s_we            = 1'b0;
        m0_ready        = 1'b0;
        m1_ready        = 1'b0;
        m0_r_data_valid = 1'b0;
        m1_r_data_valid = 1'b0;
        unique case (state)
            StOwn0: begin
                s_addr          = m0_addr;
                s_w_data        = m0_w_data;
                s_w_sel         = m0_w_sel;
                s_re            = m0_re;
                s_we            = m0_we;
                m0_ready        = s_ready & m0_we;
                m0_r_data_valid = s_r_data_valid & m0_re;
            end
            StOwn1: begin
                s_addr          = m1_addr;
                s_w_data        = m1_w_data;
                s_w_sel         = m1_w_sel;
                s_re            = m1_re;
                s_we            = m1_we;
                m1_ready        = s_ready & m1_we;
                m1_r_data_valid = s_r_data_valid & m1_re;
            end
            default: ;
        endcase
    end

    // s_re/s_we mirror the owner's request, so they double as completion and abort terms.
    assign complete = (s_re & s_r_data_valid) | (s_we & s_ready);
    assign abort    = ~s_re & ~s_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            last        <= 1'b1;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req1 && (!req0 || (RoundRobin && !last))) begin
                        state <= StOwn1;
                        last  <= 1'b1;
                        cnt   <= '0;
                    end else if (req0) begin
                        state <= StOwn0;
                        last  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                StOwn0, StOwn1: begin
                    if (complete || abort) begin
                        state <= StIdle;
                    end else if (TimeoutEn && cnt == LimitM1) begin
                        state       <= StIdle;
                        timeout_err <= 1'b1;
                    end else if (TimeoutEn) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a cycle model,
// using a round-robin instance (timeout 4) and a fixed-priority instance (timeout off).
module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    typedef struct packed {
        logic [1:0]    grant;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] sel;
        logic          re;
        logic          we;
        logic          rdy0;
        logic          rdy1;
        logic          v0;
        logic          v1;
        logic          err;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_w_data, m1_w_data, s_r_data;
    logic [SW-1:0] m0_w_sel, m1_w_sel;
    logic m0_re, m0_we, m1_re, m1_we, s_ready, s_r_data_valid;

    logic [1:0][DW-1:0] d_m0_r_data, d_m1_r_data, d_s_w_data;
    logic [1:0][AW-1:0] d_s_addr;
    logic [1:0][SW-1:0] d_s_w_sel;
    logic [1:0][1:0]    d_grant;
    logic [1:0] d_m0_ready, d_m1_ready, d_m0_rdv, d_m1_rdv, d_s_re, d_s_we, d_err;

    int total = 0;
    int bad   = 0;

    // Model state per instance: owner -1 = idle.
    int mo_owner[2] = '{-1, -1};
    int mo_last[2]  = '{1, 1};
    int mo_wait[2]  = '{0, 0};
    bit mo_err[2]   = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    bus_arbiter #(.AddrBusWidth(AW), .BusWidth(DW), .RoundRobin(1'b1), .TimeoutCycles(4)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_w_data(m0_w_data), .m0_w_sel(m0_w_sel),
        .m0_re(m0_re), .m0_we(m0_we), .m0_r_data(d_m0_r_data[0]),
        .m0_ready(d_m0_ready[0]), .m0_r_data_valid(d_m0_rdv[0]),
        .m1_addr(m1_addr), .m1_w_data(m1_w_data), .m1_w_sel(m1_w_sel),
        .m1_re(m1_re), .m1_we(m1_we), .m1_r_data(d_m1_r_data[0]),
        .m1_ready(d_m1_ready[0]), .m1_r_data_valid(d_m1_rdv[0]),
        .s_addr(d_s_addr[0]), .s_w_data(d_s_w_data[0]), .s_w_sel(d_s_w_sel[0]),
        .s_re(d_s_re[0]), .s_we(d_s_we[0]), .s_r_data(s_r_data),
        .s_ready(s_ready), .s_r_data_valid(s_r_data_valid),
        .grant(d_grant[0]), .timeout_err(d_err[0])
    );

    bus_arbiter #(.AddrBusWidth(AW), .BusWidth(DW), .RoundRobin(1'b0), .TimeoutCycles(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_w_data(m0_w_data), .m0_w_sel(m0_w_sel),
        .m0_re(m0_re), .m0_we(m0_we), .m0_r_data(d_m0_r_data[1]),
        .m0_ready(d_m0_ready[1]), .m0_r_data_valid(d_m0_rdv[1]),
        .m1_addr(m1_addr), .m1_w_data(m1_w_data), .m1_w_sel(m1_w_sel),
        .m1_re(m1_re), .m1_we(m1_we), .m1_r_data(d_m1_r_data[1]),
        .m1_ready(d_m1_ready[1]), .m1_r_data_valid(d_m1_rdv[1]),
        .s_addr(d_s_addr[1]), .s_w_data(d_s_w_data[1]), .s_w_sel(d_s_w_sel[1]),
        .s_re(d_s_re[1]), .s_we(d_s_we[1]), .s_r_data(s_r_data),
        .s_ready(s_ready), .s_r_data_valid(s_r_data_valid),
        .grant(d_grant[1]), .timeout_err(d_err[1])
    );

    function automatic bit req_re(int n);
        return (n == 0) ? m0_re : m1_re;
    endfunction

    function automatic bit req_we(int n);
        return (n == 0) ? m0_we : m1_we;
    endfunction

    // Requester that wins arbitration from idle, or -1 if nobody asks.
    function automatic int model_pick(int k);
        bit r0 = m0_re | m0_we;
        bit r1 = m1_re | m1_we;
        if (r0 && r1) return (k == 0 && mo_last[k] == 0) ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic bit model_done(int k);
        int o = mo_owner[k];
        return (req_re(o) && s_r_data_valid) || (req_we(o) && s_ready);
    endfunction

    function automatic int tmo_of(int k);
        return (k == 0) ? 4 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mo_owner[k] <= -1;
                mo_last[k]  <= 1;
                mo_wait[k]  <= 0;
                mo_err[k]   <= 1'b0;
            end else begin
                mo_err[k] <= 1'b0;
                if (mo_owner[k] < 0) begin
                    if (model_pick(k) >= 0) begin
                        mo_owner[k] <= model_pick(k);
                        mo_last[k]  <= model_pick(k);
                        mo_wait[k]  <= 0;
                    end
                end else if (model_done(k) ||
                             !(req_re(mo_owner[k]) || req_we(mo_owner[k]))) begin
                    mo_owner[k] <= -1;
                end else if (tmo_of(k) > 0 && mo_wait[k] + 1 == tmo_of(k)) begin
                    mo_owner[k] <= -1;
                    mo_err[k]   <= 1'b1;
                end else begin
                    mo_wait[k] <= mo_wait[k] + 1;
                end
            end
        end
    end

    function automatic obs_t model_out(int k);
        obs_t e = '0;
        int   o = mo_owner[k];
        e.rd0 = s_r_data;
        e.rd1 = s_r_data;
        e.err = mo_err[k];
        if (o == 0) begin
            e.grant = 2'b01;
            e.addr  = m0_addr;
            e.wdata = m0_w_data;
            e.sel   = m0_w_sel;
            e.re    = m0_re;
            e.we    = m0_we;
            e.rdy0  = s_ready & m0_we;
            e.v0    = s_r_data_valid & m0_re;
        end else if (o == 1) begin
            e.grant = 2'b10;
            e.addr  = m1_addr;
            e.wdata = m1_w_data;
            e.sel   = m1_w_sel;
            e.re    = m1_re;
            e.we    = m1_we;
            e.rdy1  = s_ready & m1_we;
            e.v1    = s_r_data_valid & m1_re;
        end
        return e;
    endfunction

    function automatic obs_t dut_out(int k);
        return {d_grant[k], d_s_addr[k], d_s_w_data[k], d_s_w_sel[k], d_s_re[k], d_s_we[k],
                d_m0_ready[k], d_m1_ready[k], d_m0_rdv[k], d_m1_rdv[k], d_err[k],
                d_m0_r_data[k], d_m1_r_data[k]};
    endfunction

    task automatic clear_inputs();
        {m0_re, m0_we, m1_re, m1_we, s_ready, s_r_data_valid} = '0;
        {m0_addr, m1_addr, m0_w_data, m1_w_data, m0_w_sel, m1_w_sel, s_r_data} = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        m0_re = 1'b1; m1_we = 1'b1; s_ready = 1'b1; s_r_data_valid = 1'b1;
        m0_addr = 32'h55;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (d_grant[k] !== 2'b00) begin
                bad++; $display("FAIL reset_grant[%0d] got=%b exp=00", k, d_grant[k]);
            end
            total++;
            if ({d_s_re[k], d_s_we[k], d_s_addr[k]} !== '0) begin
                bad++; $display("FAIL reset_s_bus[%0d] got re=%b we=%b addr=%h exp=0", k,
                                d_s_re[k], d_s_we[k], d_s_addr[k]);
            end
            total++;
            if ({d_m0_ready[k], d_m1_ready[k], d_m0_rdv[k], d_m1_rdv[k], d_err[k]} !== 5'b0) begin
                bad++; $display("FAIL reset_handshake[%0d] got=%b exp=00000", k,
                                {d_m0_ready[k], d_m1_ready[k], d_m0_rdv[k], d_m1_rdv[k], d_err[k]});
            end
        end
        @(posedge clk);
        #1 clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_basic_read();
        do_reset();
        m0_re = 1'b1; m0_addr = 32'h100;
        @(negedge clk);
        total++;
        if (d_grant[0] !== 2'b00) begin
            bad++; $display("FAIL read_arb_cycle got=%b exp=00", d_grant[0]);
        end
        @(negedge clk);
        total++;
        if ({d_grant[0], d_s_re[0], d_s_addr[0]} !== {2'b01, 1'b1, 32'h100}) begin
            bad++; $display("FAIL read_forward got grant=%b re=%b addr=%h exp 01/1/100",
                            d_grant[0], d_s_re[0], d_s_addr[0]);
        end
        s_r_data = 32'hDEADBEEF; s_r_data_valid = 1'b1;
        #1;
        total++;
        if ({d_m0_rdv[0], d_m0_r_data[0], d_m1_rdv[0]} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            bad++; $display("FAIL read_data got v0=%b data=%h v1=%b exp 1/deadbeef/0",
                            d_m0_rdv[0], d_m0_r_data[0], d_m1_rdv[0]);
        end
        @(posedge clk);
        #1 m0_re = 1'b0; s_r_data_valid = 1'b0;
        @(negedge clk);
        total++;
        if (d_grant[0] !== 2'b00) begin
            bad++; $display("FAIL read_idle_after got=%b exp=00", d_grant[0]);
        end
    endtask

    task automatic test_arbitration_order();
        logic [1:0] eg;
        do_reset();
        m0_re = 1'b1; m0_addr = 32'h10; m1_re = 1'b1; m1_addr = 32'h20;
        @(negedge clk);
        for (int t = 0; t < 4; t++) begin
            eg = (t % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            total++;
            if (d_grant[0] !== eg) begin
                bad++; $display("FAIL rr_order[%0d] got=%b exp=%b", t, d_grant[0], eg);
            end
            total++;
            if (d_grant[1] !== 2'b01) begin
                bad++; $display("FAIL fixed_order[%0d] got=%b exp=01", t, d_grant[1]);
            end
            s_r_data_valid = 1'b1;
            #1;
            total++;
            if (d_m1_rdv[1] !== 1'b0) begin
                bad++; $display("FAIL fixed_m1_starved[%0d] got=%b exp=0", t, d_m1_rdv[1]);
            end
            @(posedge clk);
            #1 s_r_data_valid = 1'b0;
            @(negedge clk);
            total++;
            if (d_grant !== 4'b0000) begin
                bad++; $display("FAIL order_bubble[%0d] got=%b exp=0000", t, d_grant);
            end
        end
        clear_inputs();
    endtask

    task automatic test_write();
        do_reset();
        m1_we = 1'b1; m1_w_sel = 4'hC; m1_w_data = 32'h12345678; m1_addr = 32'h40;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({d_grant[0], d_s_we[0], d_s_w_sel[0], d_s_w_data[0], d_m1_ready[0]} !==
            {2'b10, 1'b1, 4'hC, 32'h12345678, 1'b0}) begin
            bad++; $display("FAIL write_forward got grant=%b we=%b sel=%h data=%h rdy1=%b",
                            d_grant[0], d_s_we[0], d_s_w_sel[0], d_s_w_data[0], d_m1_ready[0]);
        end
        m0_we = 1'b1; m0_w_sel = 4'hF;
        @(negedge clk);
        total++;
        if ({d_grant[0], d_s_w_sel[0]} !== {2'b10, 4'hC}) begin
            bad++; $display("FAIL write_hold got grant=%b sel=%h exp 10/c",
                            d_grant[0], d_s_w_sel[0]);
        end
        s_ready = 1'b1;
        #1;
        total++;
        if ({d_m1_ready[0], d_m0_ready[0]} !== 2'b10) begin
            bad++; $display("FAIL write_ready got rdy1=%b rdy0=%b exp 1/0",
                            d_m1_ready[0], d_m0_ready[0]);
        end
        @(posedge clk);
        #1 s_ready = 1'b0; m1_we = 1'b0;
        @(negedge clk);
        total++;
        if ({d_grant[0], d_m1_ready[0]} !== 3'b000) begin
            bad++; $display("FAIL write_idle got grant=%b rdy1=%b exp 00/0",
                            d_grant[0], d_m1_ready[0]);
        end
        @(negedge clk);
        total++;
        if (d_grant[0] !== 2'b01) begin
            bad++; $display("FAIL write_next_owner got=%b exp=01", d_grant[0]);
        end
        m0_we = 1'b0;
        @(negedge clk);
        total++;
        if ({d_grant[0], d_err[0]} !== 3'b000) begin
            bad++; $display("FAIL abort_release got grant=%b err=%b exp 00/0",
                            d_grant[0], d_err[0]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        m0_re = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) m1_re = 1'b1;
            total++;
            if ({d_grant[0], d_err[0]} !== 3'b010) begin
                bad++; $display("FAIL timeout_wait[%0d] got grant=%b err=%b exp 01/0",
                                i, d_grant[0], d_err[0]);
            end
        end
        @(negedge clk);
        total++;
        if ({d_grant[0], d_err[0]} !== 3'b001) begin
            bad++; $display("FAIL timeout_fire got grant=%b err=%b exp 00/1",
                            d_grant[0], d_err[0]);
        end
        total++;
        if ({d_grant[1], d_err[1]} !== 3'b010) begin
            bad++; $display("FAIL timeout_disabled got grant=%b err=%b exp 01/0",
                            d_grant[1], d_err[1]);
        end
        @(negedge clk);
        total++;
        if ({d_grant[0], d_err[0]} !== 3'b100) begin
            bad++; $display("FAIL timeout_next got grant=%b err=%b exp 10/0",
                            d_grant[0], d_err[0]);
        end
        do_reset();
        m0_re = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk);
        s_r_data_valid = 1'b1;
        #1;
        total++;
        if ({d_grant[0], d_m0_rdv[0]} !== 3'b011) begin
            bad++; $display("FAIL limit_complete got grant=%b v0=%b exp 01/1",
                            d_grant[0], d_m0_rdv[0]);
        end
        @(posedge clk);
        #1 s_r_data_valid = 1'b0; m0_re = 1'b0;
        @(negedge clk);
        total++;
        if ({d_grant[0], d_err[0]} !== 3'b000) begin
            bad++; $display("FAIL limit_no_err got grant=%b err=%b exp 00/0",
                            d_grant[0], d_err[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_we = 1'b1; m1_addr = 32'h80;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({d_grant[0], d_s_we[0]} !== 3'b101) begin
            bad++; $display("FAIL midrst_own got grant=%b we=%b exp 10/1",
                            d_grant[0], d_s_we[0]);
        end
        #2 rst = 1'b1; s_ready = 1'b1;
        #1;
        total++;
        if ({d_grant[0], d_s_we[0], d_m1_ready[0]} !== 4'b0000) begin
            bad++; $display("FAIL midrst_drop got grant=%b we=%b rdy1=%b exp 00/0/0",
                            d_grant[0], d_s_we[0], d_m1_ready[0]);
        end
        @(posedge clk);
        #1 rst = 1'b0; s_ready = 1'b0; m0_re = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (d_grant !== 4'b0101) begin
            bad++; $display("FAIL midrst_rearb got=%b exp=0101", d_grant);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        bit   act[2];
        bit   done[2];
        int   kind;
        obs_t e, o;
        act = '{1'b0, 1'b0};
        done = '{1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (act[n] && (done[n] || $urandom_range(15) == 0)) begin
                    act[n] = 1'b0;
                    if (n == 0) {m0_re, m0_we} = 2'b00; else {m1_re, m1_we} = 2'b00;
                end else if (!act[n] && $urandom_range(2) == 0) begin
                    act[n] = 1'b1;
                    kind = $urandom_range(2);
                    if (n == 0) begin
                        m0_re = (kind != 1); m0_we = (kind != 0);
                        m0_addr = $urandom; m0_w_data = $urandom; m0_w_sel = 4'($urandom);
                    end else begin
                        m1_re = (kind != 1); m1_we = (kind != 0);
                        m1_addr = $urandom; m1_w_data = $urandom; m1_w_sel = 4'($urandom);
                    end
                end
            end
            s_ready = ($urandom_range(3) == 0);
            s_r_data_valid = ($urandom_range(3) == 0);
            s_r_data = $urandom;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                e = model_out(k);
                o = dut_out(k);
                total++;
                if (o !== e) begin
                    bad++; $display("FAIL random[%0d] cycle=%0d got=%h exp=%h", k, c, o, e);
                end
            end
            e = model_out(0);
            done[0] = e.rdy0 | e.v0;
            done[1] = e.rdy1 | e.v1;
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_read();
        test_arbitration_order();
        test_write();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-requester arbiter that shares one downstream memory bus between requester 0 (instruction fetch) and requester 1 (load/store unit). All three ports use the same handshake:
- A request holds re or we until completion.
- A read completes on r_data_valid.
- A write completes on ready.

The block sits in front of the bus width adapter or memory. It grants one requester per transaction, applies round-robin or fixed priority, and releases a stalled transaction on timeout.

Parameters:
AddrBusWidth, 32, address width on all ports
BusWidth, 32, data width on all ports (multiple of 8)
RoundRobin, 1, 1 = alternate priority after each grant; 0 = requester 0 always wins ties
TimeoutCycles, 255, cycles a granted transaction may wait before forced release; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
m0_addr / m1_addr  in  AddrBusWidth  requester address
m0_w_data / m1_w_data  in  BusWidth  requester write data
m0_w_sel / m1_w_sel  in  BusWidth/8  requester byte enables
m0_re / m1_re  in  1  read request, held until completion
m0_we / m1_we  in  1  write request, held until completion
m0_r_data / m1_r_data  out  BusWidth  read data, driven from s_r_data on both ports
m0_ready / m1_ready  out  1  write/transaction complete
m0_r_data_valid / m1_r_data_valid  out  1  read data valid
s_addr  out  AddrBusWidth  downstream address
s_w_data  out  BusWidth  downstream write data
s_w_sel  out  BusWidth/8  downstream byte enables
s_re  out  1  downstream read request
s_we  out  1  downstream write request
s_r_data  in  BusWidth  downstream read data
s_ready  in  1  downstream write complete
s_r_data_valid  in  1  downstream read data valid
grant  out  2  one-hot current owner; 0 when idle
timeout_err  out  1  one-cycle pulse when a transaction is force-released

Behaviour:
- Reset (asynchronous, rst=1) sets:
  - state=IDLE, grant=0, last=1, timeout counter=0, timeout_err=0.
  - All s_* outputs 0; all mN_ready and mN_r_data_valid 0.
  - Consequence of last=1: requester 0 wins the first tie.
- Reset mid-transaction drops s_re/s_we immediately, with no completion returned to either requester.
- States: IDLE, OWN0, OWN1, each registered.
- IDLE: req_n = mN_re | mN_we. Next state on the following edge:
  - only one requester asserting -> that requester's OWN state.
  - both asserting, RoundRobin=1 -> the requester != last.
  - both asserting, RoundRobin=0 -> OWN0.
  - neither -> IDLE.
- Entering OWNn sets last=n and clears the counter.
- OWNn forwarding:
  - s_addr, s_w_data, s_w_sel, s_re, s_we are combinationally driven from requester n.
  - mn_ready = s_ready & mn_we; mn_r_data_valid = s_r_data_valid & mn_re.
  - The non-owner's ready and r_data_valid are 0.
  - In IDLE, all s_* outputs are 0.
- Completion in OWNn: (mn_re & s_r_data_valid) | (mn_we & s_ready).
  - On completion, the next state is IDLE.
  - Minimum latency is request -> 1 arbitration cycle -> downstream; there is one IDLE bubble between back-to-back transactions.
- Abort: the owner deasserting both re and we while in OWNn returns to IDLE on the next edge, with no completion and no error.
- Timeout (TimeoutCycles>0):
  - The counter (width $clog2(TimeoutCycles+1)) increments each OWN cycle without completion.
  - When it equals TimeoutCycles, the next state is IDLE and timeout_err pulses for exactly one cycle, concurrent with the return to IDLE.
  - The counter saturates and never wraps.
  - Completion in the same cycle as reaching the limit counts as completion: no error.
- While not owner, a requester's request is ignored and it sees no handshake. It must keep holding re/we until it is granted.
- Simultaneous re and we from one requester are both forwarded; whichever of s_r_data_valid or s_ready arrives first completes the transaction.
- s_ready or s_r_data_valid arriving while IDLE is ignored.

Test Plan:
- Reset, then m0_re=1, addr=0x100. Expect grant=01 on cycle 1 and s_re=1, s_addr=0x100. When s_r_data_valid=1 with s_r_data=0xDEADBEEF, expect m0_r_data_valid=1, m0_r_data=0xDEADBEEF, and state IDLE next cycle.
- RoundRobin=1: both requesters hold reads for four transactions. Expect grant order 01,10,01,10 with one IDLE cycle between each.
- RoundRobin=0 with the same stimulus. Expect requester 0 granted every time and m1 never granted while m0 requests.
- m1_we=1, w_sel=0xC, w_data=0x12345678. Expect s_we=1 and s_w_sel=0xC passed through, m0_ready=0 throughout, and m1_ready=1 only in the s_ready cycle.
- TimeoutCycles=4, m0_re held, s_r_data_valid never asserted. Expect timeout_err high for 1 cycle after 4 OWN0 cycles, then grant=0; a pending m1 request is granted next. Separately, s_r_data_valid on the limit cycle gives no error.
- Assert rst mid-write in OWN1. Expect s_we=0 and grant=0 immediately; after release, a fresh arbitration with requester 0 winning the tie.
